// File: rtl/ddr_package.sv
// -----------------------------------------------------------------------------
// ddr_package
// Shared types for the DDR command/address PHY slice.
//   command_type : command codes presented on cmd_code
//   wr_state_t   : states of the write serializer FSM
//   BG_WIDTH_DEF / BA_WIDTH_DEF : default bank-group / bank address widths
// -----------------------------------------------------------------------------
package ddr_package;

   localparam int BG_WIDTH_DEF = 2;
   localparam int BA_WIDTH_DEF = 2;

   typedef enum logic [3:0] {
      ACT   = 4'd0,
      PRE   = 4'd1,
      CAS_R = 4'd2,
      CAS_W = 4'd3,
      MRS   = 4'd4,
      REF   = 4'd5,
      ZQCL  = 4'd6,
      DES   = 4'd7,
      NOP   = 4'd8
   } command_type;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_WL  = 3'd1,
      PRE_AMB  = 3'd2,
      BURST    = 3'd3,
      POST_AMB = 3'd4
   } wr_state_t;

endpackage

// File: rtl/ddr_wr_serializer.sv
// -----------------------------------------------------------------------------
// ddr_wr_serializer
// Write-data path: latency wait, DQS preamble, 8- or 4-beat burst, postamble.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_start             : CAS_W accepted this edge (only honoured in IDLE)
//   i_wr_data           : 8 beats, beat 0 in the LSBs
//   i_bc4               : burst chop (4 beats)
//   i_wl                : write latency in cycles (clamped to PREAMBLE+1)
//   o_dq_out, o_dq_oe   : data lane and its output enable
//   o_dqs_t/c, o_dqs_oe : strobe pair and its output enable
//   o_wr_done           : one-cycle pulse during the postamble
//   o_busy, o_state     : FSM not idle / FSM state for observation
// Timing: with acceptance at edge N, beat 0 is on the pins in the cycle that
// follows edge N+wl; the preamble occupies the PREAMBLE cycles before it.
// -----------------------------------------------------------------------------
module ddr_wr_serializer
   import ddr_package::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PREAMBLE   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_start,
   input  logic [8*DATA_WIDTH-1:0] i_wr_data,
   input  logic                    i_bc4,
   input  logic [4:0]              i_wl,
   output logic [DATA_WIDTH-1:0]   o_dq_out,
   output logic                    o_dq_oe,
   output logic                    o_dqs_t,
   output logic                    o_dqs_c,
   output logic                    o_dqs_oe,
   output logic                    o_wr_done,
   output logic                    o_busy,
   output wr_state_t               o_state
);

   localparam logic [4:0] WL_MIN = 5'(PREAMBLE + 1);
   localparam logic [4:0] PRE_M1 = 5'(PREAMBLE - 1);

   wr_state_t               r_state;
   logic [4:0]              r_cnt;
   logic [2:0]              r_beat;
   logic                    r_bc4;
   logic [8*DATA_WIDTH-1:0] r_data;

   logic [4:0]              w_wl_eff;
   logic [2:0]              w_last_beat;

   assign w_wl_eff    = (i_wl < WL_MIN) ? WL_MIN : i_wl;
   assign w_last_beat = r_bc4 ? 3'd3 : 3'd7;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_beat  <= '0;
         r_bc4   <= 1'b0;
         r_data  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_state <= WAIT_WL;
                  // WAIT_WL lasts wl-PREAMBLE cycles (at least one).
                  r_cnt   <= w_wl_eff - WL_MIN;
                  r_data  <= i_wr_data;
                  r_bc4   <= i_bc4;
               end
            end
            WAIT_WL: begin
               if (r_cnt == 5'd0) begin
                  r_state <= PRE_AMB;
                  r_cnt   <= PRE_M1;
               end else begin
                  r_cnt <= r_cnt - 5'd1;
               end
            end
            PRE_AMB: begin
               if (r_cnt == 5'd0) begin
                  r_state <= BURST;
                  r_beat  <= 3'd0;
               end else begin
                  r_cnt <= r_cnt - 5'd1;
               end
            end
            BURST: begin
               // The current beat always sits in the low lane of r_data.
               r_data <= r_data >> DATA_WIDTH;
               r_beat <= r_beat + 3'd1;
               if (r_beat == w_last_beat) begin
                  r_state <= POST_AMB;
               end
            end
            POST_AMB: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_dq_oe   = (r_state == BURST);
   assign o_dq_out  = o_dq_oe ? r_data[DATA_WIDTH-1:0] : '0;
   assign o_dqs_oe  = (r_state == PRE_AMB) || (r_state == BURST) || (r_state == POST_AMB);
   // Strobe is high on even beats; low in preamble, postamble and idle.
   assign o_dqs_t   = o_dq_oe & ~r_beat[0];
   assign o_dqs_c   = ~o_dqs_t;
   assign o_wr_done = (r_state == POST_AMB);
   assign o_busy    = (r_state != IDLE);
   assign o_state   = r_state;

endmodule

// File: rtl/ddr_cmd_phy.sv
// -----------------------------------------------------------------------------
// ddr_cmd_phy
// DDR4-style command/address encoder with a write-data serializer.
// Optional feature: define DDR_CA_PARITY_EN to drive even CA parity on par;
// otherwise par is tied to 0.
// Ports:
//   clock_t, reset          : clock, synchronous active-high reset
//   cmd_valid / cmd_ready   : command handshake. A command transfers on a
//                             rising edge where both are 1. cmd_ready is 0
//                             during reset and for CAS_W while a write burst
//                             is in progress; every other command is always
//                             accepted. cmd_valid may be held while ready=0.
//   cmd_code, rank_sel      : command and target rank (rank_sel < RANKS)
//   bg, ba, row, col, ap, bc4 : address fields, auto-precharge, burst chop
//   wr_data, wl             : write burst data (beat 0 in LSBs), write latency
//   cs_n .. ba_addr         : registered command pins, valid the cycle after
//                             acceptance for exactly one cycle, DES otherwise
//   dq_out, dq_oe, dqs_*    : write data lane and strobes
//   par                     : CA parity (0 unless DDR_CA_PARITY_EN)
//   wr_done                 : one-cycle pulse at the end of each write burst
//   wr_state                : write FSM state for observation
// -----------------------------------------------------------------------------
module ddr_cmd_phy
   import ddr_package::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int RANKS      = 1,
   parameter int BG_WIDTH   = BG_WIDTH_DEF,
   parameter int BA_WIDTH   = BA_WIDTH_DEF,
   parameter int ROW_WIDTH  = 18,
   parameter int COL_WIDTH  = 10,
   parameter int PREAMBLE   = 1,
   localparam int RS_WIDTH  = (RANKS > 1) ? $clog2(RANKS) : 1
) (
   input  logic                    clock_t,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  command_type             cmd_code,
   input  logic [RS_WIDTH-1:0]     rank_sel,
   input  logic [BG_WIDTH-1:0]     bg,
   input  logic [BA_WIDTH-1:0]     ba,
   input  logic [ROW_WIDTH-1:0]    row,
   input  logic [COL_WIDTH-1:0]    col,
   input  logic                    ap,
   input  logic                    bc4,
   input  logic [8*DATA_WIDTH-1:0] wr_data,
   input  logic [4:0]              wl,
   output logic [RANKS-1:0]        cs_n,
   output logic                    act_n,
   output logic                    ras_n_a16,
   output logic                    cas_n_a15,
   output logic                    we_n_a14,
   output logic                    ap_a10,
   output logic                    bc_n_a12,
   output logic                    addr17,
   output logic                    addr13,
   output logic                    addr11,
   output logic [9:0]              addr9_0,
   output logic [BG_WIDTH-1:0]     bg_addr,
   output logic [BA_WIDTH-1:0]     ba_addr,
   output logic [DATA_WIDTH-1:0]   dq_out,
   output logic                    dq_oe,
   output logic                    dqs_t,
   output logic                    dqs_c,
   output logic                    dqs_oe,
   output logic                    par,
   output logic                    wr_done,
   output wr_state_t               wr_state
);

   logic                w_accept;
   logic                w_wr_start;
   logic                w_wr_busy;
   logic [17:0]         w_row18;
   logic [9:0]          w_col10;

   logic [RANKS-1:0]    w_cs_n;
   logic                w_act_n, w_ras, w_cas, w_we;
   logic                w_a17, w_a13, w_a12, w_a11, w_a10;
   logic [9:0]          w_a9_0;
   logic [BG_WIDTH-1:0] w_bg;
   logic [BA_WIDTH-1:0] w_ba;

   logic [RANKS-1:0]    r_cs_n;
   logic                r_act_n, r_ras, r_cas, r_we;
   logic                r_a17, r_a13, r_a12, r_a11, r_a10;
   logic [9:0]          r_a9_0;
   logic [BG_WIDTH-1:0] r_bg;
   logic [BA_WIDTH-1:0] r_ba;

   // A second CAS_W has to wait for the serializer; everything else passes.
   assign cmd_ready  = ~reset & ~((cmd_code == CAS_W) & w_wr_busy);
   assign w_accept   = cmd_valid & cmd_ready;
   assign w_wr_start = w_accept & (cmd_code == CAS_W);

   // Next-cycle pin values; DES unless a non-DES command is accepted.
   always_comb begin
      w_row18 = '0;
      w_row18[ROW_WIDTH-1:0] = row;
      w_col10 = '0;
      w_col10[COL_WIDTH-1:0] = col;

      w_cs_n  = '1;
      w_act_n = 1'b1;
      w_ras   = 1'b1;
      w_cas   = 1'b1;
      w_we    = 1'b1;
      w_a17   = 1'b0;
      w_a13   = 1'b0;
      w_a12   = 1'b0;
      w_a11   = 1'b0;
      w_a10   = 1'b0;
      w_a9_0  = '0;
      w_bg    = '0;
      w_ba    = '0;

      if (w_accept && (cmd_code != DES)) begin
         for (int i = 0; i < RANKS; i++) begin
            w_cs_n[i] = (rank_sel != RS_WIDTH'(i));
         end
         // Address bits a command does not use idle high.
         w_a17  = 1'b1;
         w_a13  = 1'b1;
         w_a12  = 1'b1;
         w_a11  = 1'b1;
         w_a10  = 1'b1;
         w_a9_0 = '1;
         case (cmd_code)
            ACT: begin
               // With act_n low, ras/cas/we carry row bits 16..14.
               w_act_n = 1'b0;
               {w_a17, w_ras, w_cas, w_we, w_a13, w_a12, w_a11, w_a10, w_a9_0} = w_row18;
               w_bg = bg;
               w_ba = ba;
            end
            PRE: begin
               {w_ras, w_cas, w_we} = 3'b010;
               w_a10 = ap;
               w_bg  = bg;
               w_ba  = ba;
            end
            CAS_R, CAS_W: begin
               {w_ras, w_cas, w_we} = (cmd_code == CAS_R) ? 3'b101 : 3'b100;
               w_a12  = ~bc4;
               w_a10  = ap;
               w_a9_0 = w_col10;
               w_bg   = bg;
               w_ba   = ba;
            end
            MRS: begin
               // Opcode on every address pin not shared with ras/cas/we.
               {w_ras, w_cas, w_we} = 3'b000;
               w_a17 = w_row18[17];
               {w_a13, w_a12, w_a11, w_a10, w_a9_0} = w_row18[13:0];
               w_bg  = bg;
               w_ba  = ba;
            end
            REF: begin
               {w_ras, w_cas, w_we} = 3'b001;
            end
            ZQCL: begin
               {w_ras, w_cas, w_we} = 3'b110;
               w_a10 = 1'b1;
            end
            default: begin
               // NOP: selected rank, ras/cas/we high.
            end
         endcase
      end
   end

   always_ff @(posedge clock_t) begin
      if (reset) begin
         r_cs_n  <= '1;
         r_act_n <= 1'b1;
         r_ras   <= 1'b1;
         r_cas   <= 1'b1;
         r_we    <= 1'b1;
         r_a17   <= 1'b0;
         r_a13   <= 1'b0;
         r_a12   <= 1'b0;
         r_a11   <= 1'b0;
         r_a10   <= 1'b0;
         r_a9_0  <= '0;
         r_bg    <= '0;
         r_ba    <= '0;
      end else begin
         r_cs_n  <= w_cs_n;
         r_act_n <= w_act_n;
         r_ras   <= w_ras;
         r_cas   <= w_cas;
         r_we    <= w_we;
         r_a17   <= w_a17;
         r_a13   <= w_a13;
         r_a12   <= w_a12;
         r_a11   <= w_a11;
         r_a10   <= w_a10;
         r_a9_0  <= w_a9_0;
         r_bg    <= w_bg;
         r_ba    <= w_ba;
      end
   end

   assign cs_n      = r_cs_n;
   assign act_n     = r_act_n;
   assign ras_n_a16 = r_ras;
   assign cas_n_a15 = r_cas;
   assign we_n_a14  = r_we;
   assign addr17    = r_a17;
   assign addr13    = r_a13;
   assign bc_n_a12  = r_a12;
   assign addr11    = r_a11;
   assign ap_a10    = r_a10;
   assign addr9_0   = r_a9_0;
   assign bg_addr   = r_bg;
   assign ba_addr   = r_ba;

`ifdef DDR_CA_PARITY_EN
   // Parity is computed from the next-cycle pin values so it lands in the
   // same cycle as the command it covers.
   logic r_par;
   always_ff @(posedge clock_t) begin
      if (reset) begin
         r_par <= 1'b0;
      end else begin
         r_par <= ^{w_act_n, w_ras, w_cas, w_we, w_a17, w_a13, w_a12, w_a11,
                    w_a10, w_a9_0, w_bg, w_ba};
      end
   end
   assign par = r_par;
`else
   assign par = 1'b0;
`endif

   ddr_wr_serializer #(
      .DATA_WIDTH (DATA_WIDTH),
      .PREAMBLE   (PREAMBLE)
   ) u_wr_serializer (
      .clk       (clock_t),
      .rst       (reset),
      .i_start   (w_wr_start),
      .i_wr_data (wr_data),
      .i_bc4     (bc4),
      .i_wl      (wl),
      .o_dq_out  (dq_out),
      .o_dq_oe   (dq_oe),
      .o_dqs_t   (dqs_t),
      .o_dqs_c   (dqs_c),
      .o_dqs_oe  (dqs_oe),
      .o_wr_done (wr_done),
      .o_busy    (w_wr_busy),
      .o_state   (wr_state)
   );

endmodule

// File: tb/tb_ddr_cmd_phy.sv
// -----------------------------------------------------------------------------
// tb_ddr_cmd_phy
// Directed bench for ddr_cmd_phy (RANKS=2, PREAMBLE=1, DATA_WIDTH=8).
// Command encodings come from a hand-filled vector table; write bursts,
// handshake back-pressure and reset abort are hand-written sequences.
// Cycle naming: inputs are applied just after a rising edge, the next edge
// samples them, and outputs are observed 1 ns after that edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ddr_cmd_phy;
   import ddr_package::*;

   localparam int DW       = 8;
   localparam int RANKS    = 2;
   localparam int PREAMBLE = 1;

   // ---------------- clock / reset ----------------
   logic clock_t = 1'b0;
   logic reset;
   always #5 clock_t = ~clock_t;

   // ---------------- DUT signals ----------------
   logic          cmd_valid;
   logic          cmd_ready;
   command_type   cmd_code;
   logic [0:0]    rank_sel;
   logic [1:0]    bg, ba;
   logic [17:0]   row;
   logic [9:0]    col;
   logic          ap, bc4;
   logic [63:0]   wr_data;
   logic [4:0]    wl;
   logic [1:0]    cs_n;
   logic          act_n, ras_n_a16, cas_n_a15, we_n_a14, ap_a10, bc_n_a12;
   logic          addr17, addr13, addr11;
   logic [9:0]    addr9_0;
   logic [1:0]    bg_addr, ba_addr;
   logic [DW-1:0] dq_out;
   logic          dq_oe, dqs_t, dqs_c, dqs_oe, par, wr_done;
   wr_state_t     wr_state;

   ddr_cmd_phy #(
      .DATA_WIDTH (DW),
      .RANKS      (RANKS),
      .BG_WIDTH   (2),
      .BA_WIDTH   (2),
      .ROW_WIDTH  (18),
      .COL_WIDTH  (10),
      .PREAMBLE   (PREAMBLE)
   ) dut (
      .clock_t   (clock_t),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_code  (cmd_code),
      .rank_sel  (rank_sel),
      .bg        (bg),
      .ba        (ba),
      .row       (row),
      .col       (col),
      .ap        (ap),
      .bc4       (bc4),
      .wr_data   (wr_data),
      .wl        (wl),
      .cs_n      (cs_n),
      .act_n     (act_n),
      .ras_n_a16 (ras_n_a16),
      .cas_n_a15 (cas_n_a15),
      .we_n_a14  (we_n_a14),
      .ap_a10    (ap_a10),
      .bc_n_a12  (bc_n_a12),
      .addr17    (addr17),
      .addr13    (addr13),
      .addr11    (addr11),
      .addr9_0   (addr9_0),
      .bg_addr   (bg_addr),
      .ba_addr   (ba_addr),
      .dq_out    (dq_out),
      .dq_oe     (dq_oe),
      .dqs_t     (dqs_t),
      .dqs_c     (dqs_c),
      .dqs_oe    (dqs_oe),
      .par       (par),
      .wr_done   (wr_done),
      .wr_state  (wr_state)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(posedge clock_t);
      #1;
   endtask

   function automatic logic [24:0] pins_now();
      return {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14,
              addr17, addr13, bc_n_a12, addr11, ap_a10, addr9_0, bg_addr, ba_addr};
   endfunction

   // Expected pins: {cs_n, {act,ras,cas,we}, {a17,a13,a12,a11,a10}, a9_0, bg, ba}
   function automatic logic [24:0] pins_exp(input logic [1:0] e_cs, input logic [3:0] e_arcw,
                                            input logic [4:0] e_hi, input logic [9:0] e_lo,
                                            input logic [1:0] e_bg, input logic [1:0] e_ba);
      return {e_cs, e_arcw, e_hi, e_lo, e_bg, e_ba};
   endfunction

   function automatic logic par_exp(input logic [24:0] p);
`ifdef DDR_CA_PARITY_EN
      return ^p[22:0];
`else
      return (p[0] & 1'b0);
`endif
   endfunction

   // {dq_oe, dq_out, dqs_oe, dqs_t, dqs_c, wr_done}
   function automatic logic [12:0] wr_now();
      return {dq_oe, dq_out, dqs_oe, dqs_t, dqs_c, wr_done};
   endfunction

   // ---------------- command vector table ----------------
   typedef struct {
      command_type code;
      logic        rs;
      logic [1:0]  bg;
      logic [1:0]  ba;
      logic [17:0] row;
      logic [9:0]  col;
      logic        ap;
      logic        bc4;
      logic [1:0]  e_cs;
      logic [3:0]  e_arcw;
      logic [4:0]  e_hi;
      logic [9:0]  e_lo;
      logic [1:0]  e_bg;
      logic [1:0]  e_ba;
   } vec_t;

   vec_t vecs[10];

   localparam logic [24:0] DES_PINS = {2'b11, 4'b1111, 5'b00000, 10'h000, 2'd0, 2'd0};

   // Drive a CAS_W and compare the write-path outputs cycle by cycle.
   task automatic run_write(input string name, input logic [4:0] wl_in, input logic bc4_in,
                            input logic [63:0] data);
      int wle;
      int nb;
      int b;
      logic [12:0] exp_w;
      wle = (int'(wl_in) < PREAMBLE + 1) ? PREAMBLE + 1 : int'(wl_in);
      nb  = bc4_in ? 4 : 8;
      cmd_code = CAS_W; cmd_valid = 1'b1; rank_sel = 1'b0; col = 10'h008;
      ap = 1'b0; bc4 = bc4_in; wr_data = data; wl = wl_in; bg = 2'd0; ba = 2'd0;
      #1;
      check({name, "_ready"}, 64'(cmd_ready), 64'd1);
      tick();
      // Scramble inputs to prove they were captured at acceptance.
      cmd_valid = 1'b0; wr_data = ~data; bc4 = ~bc4_in; wl = 5'd31;
      check({name, "_pins"}, 64'(pins_now()),
            64'(pins_exp(2'b10, 4'b1100, {1'b1, 1'b1, ~bc4_in, 1'b1, 1'b0}, 10'h008, 2'd0, 2'd0)));
      for (int o = 1; o <= wle + nb + 3; o++) begin
         if (o >= 1 + wle - PREAMBLE && o <= wle) begin
            exp_w = {1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
         end else if (o >= 1 + wle && o < 1 + wle + nb) begin
            b = o - 1 - wle;
            exp_w = {1'b1, data[8*b +: 8], 1'b1, ~b[0], b[0], 1'b0};
         end else if (o == 1 + wle + nb) begin
            exp_w = {1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
         end else begin
            exp_w = {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
         end
         check($sformatf("%s_c%0d", name, o), 64'(wr_now()), 64'(exp_w));
         tick();
      end
   endtask

   initial begin
      logic [24:0] ep;
      logic [17:0] rrow;
      logic [1:0]  rbg, rba;
      logic        rrs;
      logic        seen_done, seen_oe;

      vecs[0] = '{ACT,   1'b1, 2'd2, 2'd1, 18'h1ABCD, 10'h000, 1'b0, 1'b0, 2'b01, 4'b0110, 5'b01010, 10'h3CD, 2'd2, 2'd1};
      vecs[1] = '{PRE,   1'b0, 2'd1, 2'd3, 18'h12345, 10'h000, 1'b1, 1'b0, 2'b10, 4'b1010, 5'b11111, 10'h3FF, 2'd1, 2'd3};
      vecs[2] = '{PRE,   1'b1, 2'd0, 2'd0, 18'h00000, 10'h155, 1'b0, 1'b1, 2'b01, 4'b1010, 5'b11110, 10'h3FF, 2'd0, 2'd0};
      vecs[3] = '{CAS_R, 1'b0, 2'd3, 2'd2, 18'h3FFFF, 10'h155, 1'b1, 1'b0, 2'b10, 4'b1101, 5'b11111, 10'h155, 2'd3, 2'd2};
      vecs[4] = '{CAS_R, 1'b1, 2'd0, 2'd1, 18'h00000, 10'h2AA, 1'b0, 1'b1, 2'b01, 4'b1101, 5'b11010, 10'h2AA, 2'd0, 2'd1};
      vecs[5] = '{MRS,   1'b0, 2'd1, 2'd2, 18'h25A5A, 10'h000, 1'b0, 1'b0, 2'b10, 4'b1000, 5'b10110, 10'h25A, 2'd1, 2'd2};
      vecs[6] = '{REF,   1'b1, 2'd3, 2'd3, 18'h00000, 10'h000, 1'b0, 1'b0, 2'b01, 4'b1001, 5'b11111, 10'h3FF, 2'd0, 2'd0};
      vecs[7] = '{ZQCL,  1'b0, 2'd3, 2'd3, 18'h00000, 10'h000, 1'b0, 1'b0, 2'b10, 4'b1110, 5'b11111, 10'h3FF, 2'd0, 2'd0};
      vecs[8] = '{NOP,   1'b1, 2'd2, 2'd2, 18'h0F0F0, 10'h0F0, 1'b1, 1'b1, 2'b01, 4'b1111, 5'b11111, 10'h3FF, 2'd0, 2'd0};
      vecs[9] = '{DES,   1'b0, 2'd1, 2'd1, 18'h3FFFF, 10'h3FF, 1'b1, 1'b1, 2'b11, 4'b1111, 5'b00000, 10'h000, 2'd0, 2'd0};

      // ---------------- reset, with a command presented ----------------
      reset = 1'b1; cmd_valid = 1'b1; cmd_code = ACT; rank_sel = 1'b1;
      bg = 2'd3; ba = 2'd3; row = 18'h1ABCD; col = 10'h3FF; ap = 1'b1; bc4 = 1'b0;
      wr_data = 64'h0; wl = 5'd0;
      #1;
      check("reset_ready", 64'(cmd_ready), 64'd0);
      tick();
      tick();
      check("reset_pins", 64'(pins_now()), 64'(DES_PINS));
      check("reset_wr", 64'({dq_oe, dq_out, dqs_oe, dqs_t, dqs_c, wr_done, par}),
            64'({1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
      check("reset_ready_held", 64'(cmd_ready), 64'd0);
      reset = 1'b0; cmd_valid = 1'b0;
      #1;
      check("post_reset_ready", 64'(cmd_ready), 64'd1);
      tick();
      check("post_reset_des", 64'(pins_now()), 64'(DES_PINS));

      // ---------------- command encoding table ----------------
      for (int i = 0; i < 10; i++) begin
         cmd_code = vecs[i].code; rank_sel = vecs[i].rs; bg = vecs[i].bg; ba = vecs[i].ba;
         row = vecs[i].row; col = vecs[i].col; ap = vecs[i].ap; bc4 = vecs[i].bc4;
         cmd_valid = 1'b1;
         #1;
         check($sformatf("vec%0d_ready", i), 64'(cmd_ready), 64'd1);
         tick();
         cmd_valid = 1'b0;
         ep = pins_exp(vecs[i].e_cs, vecs[i].e_arcw, vecs[i].e_hi, vecs[i].e_lo, vecs[i].e_bg, vecs[i].e_ba);
         check($sformatf("vec%0d_pins", i), 64'(pins_now()), 64'(ep));
         check($sformatf("vec%0d_par", i), 64'(par), 64'(par_exp(ep)));
         tick();
         check($sformatf("vec%0d_des", i), 64'(pins_now()), 64'(DES_PINS));
      end

      // ---------------- random MRS values (address + parity) ----------------
      for (int i = 0; i < 100; i++) begin
         rrow = 18'($urandom_range(0, 18'h3FFFF));
         rbg  = 2'($urandom_range(0, 3));
         rba  = 2'($urandom_range(0, 3));
         rrs  = 1'($urandom_range(0, 1));
         cmd_code = MRS; rank_sel = rrs; row = rrow; bg = rbg; ba = rba; cmd_valid = 1'b1;
         tick();
         cmd_valid = 1'b0;
         ep = pins_exp(rrs ? 2'b01 : 2'b10, 4'b1000,
                       {rrow[17], rrow[13], rrow[12], rrow[11], rrow[10]}, rrow[9:0], rbg, rba);
         check($sformatf("mrs%0d_pins", i), 64'(pins_now()), 64'(ep));
         check($sformatf("mrs%0d_par", i), 64'(par), 64'(par_exp(ep)));
      end
      tick();

      // ---------------- write bursts ----------------
      run_write("wr_wl9", 5'd9, 1'b0, 64'h0807060504030201);
      run_write("wr_bc4_wl0", 5'd0, 1'b1, 64'hDEADBEEFCAFEF00D);
      run_write("wr_wl1", 5'd1, 1'b0, 64'h1122334455667788);
      run_write("wr_wl2_bc4", 5'd2, 1'b1, 64'hA5A5A5A55AC3E7F1);

      // ---------------- CAS_W back-pressure with PRE accepted mid-burst ----------------
      cmd_code = CAS_W; cmd_valid = 1'b1; rank_sel = 1'b0; bc4 = 1'b0; wl = 5'd2;
      wr_data = 64'h0F0E0D0C0B0A0908; ap = 1'b0; bg = 2'd0; ba = 2'd0;
      tick();
      for (int o = 1; o <= 12; o++) begin
         if (o == 6) begin
            check("bp_pre_pins", 64'(pins_now()),
                  64'(pins_exp(2'b01, 4'b1010, 5'b11111, 10'h3FF, 2'd2, 2'd1)));
            check("bp_pre_dq", 64'({dq_oe, dq_out}), 64'({1'b1, 8'h0B}));
         end
         if (o == 8) begin
            check("bp_reject_des", 64'(pins_now()), 64'(DES_PINS));
         end
         cmd_valid = 1'b1;
         cmd_code  = (o == 5) ? PRE : CAS_W;
         rank_sel  = 1'b1; ap = 1'b1; bg = 2'd2; ba = 2'd1;
         #1;
         check($sformatf("bp_ready_c%0d", o), 64'(cmd_ready), 64'((o == 5) || (o >= 12)));
         if (o == 12) cmd_valid = 1'b0;
         tick();
      end
      tick();

      // ---------------- reset during beat 3 ----------------
      cmd_code = CAS_W; cmd_valid = 1'b1; rank_sel = 1'b0; bc4 = 1'b0; wl = 5'd2;
      wr_data = 64'h8877665544332211;
      tick();
      cmd_valid = 1'b0;
      for (int o = 1; o < 6; o++) tick();
      check("abort_beat3", 64'({dq_oe, dq_out}), 64'({1'b1, 8'h44}));
      reset = 1'b1;
      #1;
      check("abort_ready", 64'(cmd_ready), 64'd0);
      tick();
      check("abort_outputs", 64'(wr_now()), 64'({1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
      reset = 1'b0;
      seen_done = 1'b0; seen_oe = 1'b0;
      for (int o = 0; o < 12; o++) begin
         tick();
         seen_done = seen_done | wr_done;
         seen_oe   = seen_oe | dq_oe | dqs_oe;
      end
      check("abort_no_done", 64'(seen_done), 64'd0);
      check("abort_no_beats", 64'(seen_oe), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Safety net in case the stimulus ever stalls.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

endmodule
